// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier.
// Operands load over DataIn with per-register load enables; a start pulse
// launches one multiply that retires one multiplier bit per clock. The
// 2N-bit Product is registered and flagged by a one-cycle result_valid.
// Optional feature macro: MULT_EARLY_EXIT_EN (finish as soon as the
// remaining multiplier bits are all zero).
module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   DataIn,
  input  logic           ld_M,
  input  logic           ld_Q,
  input  logic           start,
  output logic           busy,
  output logic           result_valid,
  output logic [2*N-1:0] Product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]     state;
  logic [N-1:0]   M;
  logic [N-1:0]   Qop;
  logic [N:0]     A;
  logic [N-1:0]   Q;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   addend;
  logic [N:0]     sum;
  logic [2*N-1:0] shifted;
  logic           last;
  logic           done_early;
  logic [2*N-1:0] early_prod;

  // One iteration: conditional add of M, then the {sum,Q} right shift.
  // A[N] is always 0 entering an iteration, so adding full A equals adding A[N-1:0].
  always_comb begin
    addend  = Q[0] ? M : '0;
    sum     = A + {1'b0, addend};
    shifted = {sum, Q[N-1:1]};
    last    = (cnt == LAST_CNT);
  end

`ifdef MULT_EARLY_EXIT_EN
  localparam logic [CW:0] N_W = (CW+1)'(N);
  logic [N-1:0] pend_mask;
  logic [CW:0]  shamt;

  // Detect that every unprocessed multiplier bit is zero and pre-compute
  // the remaining shifts so the final value matches a full-length run.
  always_comb begin
    pend_mask  = {N{1'b1}} >> cnt;
    done_early = ((Q & pend_mask) == '0);
    shamt      = N_W - {1'b0, cnt};
    early_prod = {A[N-1:0], Q} >> shamt;
  end
`else
  // Early exit disabled: every multiply runs exactly N iterations.
  always_comb begin
    done_early = 1'b0;
    early_prod = '0;
  end
`endif

  // Control FSM, operand registers and datapath state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      Product      <= '0;
      M            <= '0;
      Qop          <= '0;
      A            <= '0;
      Q            <= '0;
      cnt          <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            A     <= '0;
            Q     <= Qop;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (ld_M) M   <= DataIn;
            if (ld_Q) Qop <= DataIn;
          end
        end
        RUN: begin
          if (done_early) begin
            Product      <= early_prod;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            A   <= {1'b0, sum[N:1]};
            Q   <= {sum[0], Q[N-1:1]};
            cnt <= cnt + 1'b1;
            if (last) begin
              Product      <= shifted;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed self-checking bench for the default
// (no early exit) build of shift_add_multiplier with N=4.
module tb_shift_add_multiplier;

  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   DataIn;
  logic           ld_M;
  logic           ld_Q;
  logic           start;
  logic           busy;
  logic           result_valid;
  logic [2*N-1:0] Product;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .DataIn       (DataIn),
    .ld_M         (ld_M),
    .ld_Q         (ld_Q),
    .start        (start),
    .busy         (busy),
    .result_valid (result_valid),
    .Product      (Product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [N-1:0] m, input logic [N-1:0] q);
    ld_M = 1'b1; DataIn = m;
    step();
    ld_M = 1'b0; ld_Q = 1'b1; DataIn = q;
    step();
    ld_Q = 1'b0; DataIn = '0;
  endtask

  // Pulse start, wait (bounded) for result_valid, check latency and value.
  task automatic run_mult(input string tag, input logic [31:0] exp_prod, input int exp_lat);
    int lat;
    start = 1'b1;
    lat = 0;
    do begin
      step();
      start = 1'b0;
      lat++;
    end while (!result_valid && lat < 20);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_product"}, Product, exp_prod);
    step();
    check({tag, "_valid_drop"}, result_valid, 1'b0);
  endtask

  initial begin
    int rv_seen;
    int lat;
    reset = 1'b0; DataIn = '0; ld_M = 1'b0; ld_Q = 1'b0; start = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_product", Product, 8'd0);
    step();
    reset = 1'b1;
    step();

    // 13 x 11 = 143 with cycle-by-cycle busy/valid checks
    load(4'd13, 4'd11);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("mul1_busy", busy, 1'b1);
      check("mul1_valid_low", result_valid, 1'b0);
      step();
    end
    check("mul1_busy_done", busy, 1'b0);
    check("mul1_valid", result_valid, 1'b1);
    check("mul1_product", Product, 8'd143);
    step();
    check("mul1_valid_drop", result_valid, 1'b0);
    check("mul1_product_hold", Product, 8'd143);

    // carry path, then reuse of operands with no reload
    load(4'd15, 4'd15);
    run_mult("mul_15x15", 8'd225, 5);
    run_mult("mul_15x15_again", 8'd225, 5);

    // zero multiplier: full latency without early exit
    load(4'd9, 4'd0);
    run_mult("mul_9x0", 8'd0, 5);

    // inputs ignored while running
    load(4'd7, 4'd6);
    start = 1'b1;
    step();
    ld_M = 1'b1; DataIn = 4'd2;
    step();
    ld_M = 1'b0; ld_Q = 1'b1; DataIn = 4'd3;
    step();
    ld_Q = 1'b0; start = 1'b0; DataIn = '0;
    lat = 3;
    while (!result_valid && lat < 20) begin
      step();
      lat++;
    end
    check("ignore_latency", lat, 5);
    check("ignore_product", Product, 8'd42);
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (result_valid) rv_seen++;
    end
    check("ignore_no_second_valid", rv_seen, 0);
    run_mult("ignore_operands_kept", 8'd42, 5);

    // reset in the middle of a run
    load(4'd12, 4'd12);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_product", Product, 8'd0);
    check("abort_valid", result_valid, 1'b0);
    step();
    reset = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (result_valid) rv_seen++;
    end
    check("abort_no_valid", rv_seen, 0);
    load(4'd3, 4'd5);
    run_mult("after_abort_3x5", 8'd15, 5);

    // start held high: one result every N+1 cycles
    load(4'd5, 4'd6);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      do begin
        step();
        lat++;
      end while (!result_valid && lat < 20);
      check("held_period", lat, 5);
      check("held_product", Product, 8'd30);
    end
    start = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
